squared_seq: RTL

Sequencer for the `squared` power stage of the log-mel pipeline. It accepts the FFT bin stream over a valid/ready handshake and tags each sample with its bin index (0..N_BINS-1) and group number (0..N_GROUPS-1), including first/last framing. It drives `squared` through a registered `di_en` strobe. Because `squared` has no backpressure, it throttles issue with a credit counter mirroring the downstream buffer, and it reports run completion once every issued sample has come back out of `squared`.

---
 rtl/squared_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/squared_seq.sv
// Issue sequencer for the `squared` power stage: tags FFT bins with index/group
// and framing, throttles on downstream credits, and signals run completion.
module squared_seq #(
  parameter int I_BW     = 14,
  parameter int N_BINS   = 513,
  parameter int N_GROUPS = 89,
  parameter int CREDITS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic signed [I_BW-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic signed [I_BW-1:0] sq_data_i,
  output logic                   sq_di_en,
  output logic [9:0]             sq_in_group_idx,
  output logic [6:0]             sq_in_group_num,
  output logic                   sq_is_first_in,
  output logic                   sq_is_last_in,
  input  logic                   sq_do_en,
  input  logic                   credit_ret
);

  localparam int            CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [9:0]    LAST_BIN = 10'(N_BINS - 1);
  localparam logic [6:0]    LAST_GRP = 7'(N_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  logic [9:0]    bin_cnt;
  logic [6:0]    grp_cnt;
  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nxt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic          issue;
  logic          issue_go;
  logic          credit_err;
  logic          retire_err;
  logic          last_bin;
  logic          last_sample;

  // s_ready looks only at registered state so upstream never sees a loop through s_valid.
  assign s_ready     = (state == RUN) && (credits != '0);
  assign issue       = s_valid && s_ready;
  // A handshake coinciding with abort is dropped: no strobe, no slot consumed.
  assign issue_go    = issue && !abort;
  assign last_bin    = (bin_cnt == LAST_BIN);
  assign last_sample = last_bin && (grp_cnt == LAST_GRP);

  // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    credits_nxt = credits;
    credit_err  = 1'b0;
    if (issue_go && !credit_ret) begin
      credits_nxt = credits - CW'(1);
    end else if (credit_ret && !issue_go) begin
      if (credits == CRED_MAX) credit_err  = 1'b1;
      else                     credits_nxt = credits + CW'(1);
    end
  end

  always_comb begin
    outstanding_nxt = outstanding;
    retire_err      = 1'b0;
    if (issue_go && !sq_do_en) begin
      if (outstanding != CRED_MAX) outstanding_nxt = outstanding + CW'(1);
    end else if (sq_do_en && !issue_go) begin
      if (outstanding == '0) retire_err      = 1'b1;
      else                   outstanding_nxt = outstanding - CW'(1);
    end
    if (abort) outstanding_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bin_cnt         <= '0;
      grp_cnt         <= '0;
      credits         <= CRED_MAX;
      outstanding     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      sq_data_i       <= '0;
      sq_di_en        <= 1'b0;
      sq_in_group_idx <= '0;
      sq_in_group_num <= '0;
      sq_is_first_in  <= 1'b0;
      sq_is_last_in   <= 1'b0;
    end else begin
      credits     <= credits_nxt;
      outstanding <= outstanding_nxt;
      if (credit_err || retire_err) err <= 1'b1;

      sq_di_en <= issue_go;
      done     <= 1'b0;
      if (issue_go) begin
        sq_data_i       <= s_data;
        sq_in_group_idx <= bin_cnt;
        sq_in_group_num <= grp_cnt;
        sq_is_first_in  <= (bin_cnt == '0) && (grp_cnt == '0);
        sq_is_last_in   <= last_sample;
      end

      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        bin_cnt <= '0;
        grp_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              busy    <= 1'b1;
              bin_cnt <= '0;
              grp_cnt <= '0;
            end
          end
          RUN: begin
            if (issue_go) begin
              if (last_sample) begin
                state   <= DRAIN;
                bin_cnt <= '0;
                grp_cnt <= '0;
              end else if (last_bin) begin
                bin_cnt <= '0;
                grp_cnt <= grp_cnt + 7'd1;
              end else begin
                bin_cnt <= bin_cnt + 10'd1;
              end
            end
          end
          DRAIN: begin
            // Completion counts a retire landing on this very cycle.
            if (outstanding_nxt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
